// File: rtl/carrier_pkg.sv
// Shared types and default widths for the sin/cos carrier burst sequencer.
package carrier_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int CARRIER_ACC_W   = 16;
   localparam int CARRIER_ADDR_W  = 8;
   localparam int CARRIER_LEN_W   = 16;
   localparam int CARRIER_ROM_LAT = 1;

endpackage

// File: rtl/carrier_phase_acc.sv
// NCO phase accumulator: registered ROM address is the accumulator MSBs plus a phase offset.
// i_clear restarts from phase zero and issues that first address in the same edge.
module carrier_phase_acc #(
   parameter int ACC_W  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_en,
   input  logic [ACC_W-1:0]  i_fcw,
   input  logic [ADDR_W-1:0] i_phase,
   output logic [ADDR_W-1:0] o_addr
);

   logic [ACC_W-1:0]  r_acc;
   logic [ADDR_W-1:0] r_addr;
   logic [ACC_W-1:0]  w_base;

   assign w_base = i_clear ? '0 : r_acc;
   assign o_addr = r_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc  <= '0;
         r_addr <= '0;
      end else if (i_clear || i_en) begin
         r_acc  <= w_base + i_fcw;
         r_addr <= w_base[ACC_W-1 -: ADDR_W] + i_phase;
      end
   end

endmodule

// File: rtl/carrier_sequencer.sv
// Burst controller for the sin/cos carrier ROMs: issues len phase-stepped addresses and
// tags the ROM outputs with valid/last after the ROM read latency.
//
//   state | meaning
//   IDLE  | waiting for start; configuration accepted here
//   RUN   | issuing one ROM address per cycle
//   DRAIN | all addresses issued, waiting for the last sample to leave the ROM
module carrier_sequencer
   import carrier_pkg::*;
#(
   parameter int ACC_W   = CARRIER_ACC_W,
   parameter int ADDR_W  = CARRIER_ADDR_W,
   parameter int LEN_W   = CARRIER_LEN_W,
   parameter int ROM_LAT = CARRIER_ROM_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ACC_W-1:0]  cfg_fcw,
   input  logic [ADDR_W-1:0] cfg_phase,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              sample_valid,
   output logic              sample_last
);

   state_t            r_state;
   state_t            w_next;
   logic [ACC_W-1:0]  r_fcw;
   logic [ADDR_W-1:0] r_phase;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_rem;
   logic [ROM_LAT:0]  r_vpipe;
   logic [ROM_LAT:0]  r_lpipe;
   logic              r_done;

   logic              w_cfg_acc;
   logic [ACC_W-1:0]  w_fcw;
   logic [ADDR_W-1:0] w_phase;
   logic [LEN_W-1:0]  w_len;
   logic              w_clear;
   logic              w_en;
   logic              w_issue;
   logic              w_last;
   logic              w_done_set;
   logic              w_flush;

   // A config accepted in the start cycle feeds the burst directly.
   assign w_cfg_acc = cfg_valid && (r_state == IDLE);
   assign w_fcw     = w_cfg_acc ? cfg_fcw   : r_fcw;
   assign w_phase   = w_cfg_acc ? cfg_phase : r_phase;
   assign w_len     = w_cfg_acc ? cfg_len   : r_len;
   assign w_issue   = w_clear || w_en;
   assign w_flush   = abort && (r_state != IDLE);

   always_comb begin
      w_next     = r_state;
      w_clear    = 1'b0;
      w_en       = 1'b0;
      w_last     = 1'b0;
      w_done_set = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start && !abort) begin
               if (w_len == '0) begin
                  w_done_set = 1'b1;
               end else begin
                  w_clear = 1'b1;
                  w_last  = (w_len == LEN_W'(1));
                  w_next  = w_last ? DRAIN : RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               w_next = IDLE;
            end else begin
               w_en   = 1'b1;
               w_last = (r_rem == LEN_W'(1));
               if (w_last) w_next = DRAIN;
            end
         end
         DRAIN: begin
            if (abort) begin
               w_next = IDLE;
            end else if (r_lpipe[ROM_LAT]) begin
               w_next     = IDLE;
               w_done_set = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_fcw   <= '0;
         r_phase <= '0;
         r_len   <= '0;
         r_rem   <= '0;
         r_vpipe <= '0;
         r_lpipe <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_done_set;
         if (w_cfg_acc) begin
            r_fcw   <= cfg_fcw;
            r_phase <= cfg_phase;
            r_len   <= cfg_len;
         end
         // r_rem counts addresses still to issue after the current one.
         if (w_clear) begin
            r_rem <= w_len - LEN_W'(1);
         end else if (w_en) begin
            r_rem <= r_rem - LEN_W'(1);
         end
         if (w_flush) begin
            r_vpipe <= '0;
            r_lpipe <= '0;
         end else begin
            r_vpipe <= {r_vpipe[ROM_LAT-1:0], w_issue};
            r_lpipe <= {r_lpipe[ROM_LAT-1:0], w_issue && w_last};
         end
      end
   end

   carrier_phase_acc #(
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W)
   ) u_phase_acc (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_clear),
      .i_en    (w_en),
      .i_fcw   (w_fcw),
      .i_phase (w_phase),
      .o_addr  (rom_addr)
   );

   assign cfg_ready    = (r_state == IDLE);
   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign sample_valid = r_vpipe[ROM_LAT];
   assign sample_last  = r_lpipe[ROM_LAT];

endmodule

// File: tb/tb_carrier_sequencer.sv
// Directed bench for carrier_sequencer: ROM_LAT=1 instance for most scenarios, ROM_LAT=3 for latency.
module tb_carrier_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        cfg_valid = 1'b0, start = 1'b0, abort = 1'b0;
   logic [15:0] cfg_fcw = '0, cfg_len = '0;
   logic [7:0]  cfg_phase = '0;
   logic        cfg_ready, busy, done, sample_valid, sample_last;
   logic [7:0]  rom_addr;

   logic        cfg_valid3 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
   logic [15:0] cfg_fcw3 = '0, cfg_len3 = '0;
   logic [7:0]  cfg_phase3 = '0;
   logic        cfg_ready3, busy3, done3, sample_valid3, sample_last3;
   logic [7:0]  rom_addr3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   carrier_sequencer #(.ACC_W(16), .ADDR_W(8), .LEN_W(16), .ROM_LAT(1)) u_dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_fcw(cfg_fcw), .cfg_phase(cfg_phase), .cfg_len(cfg_len),
      .start(start), .abort(abort), .busy(busy), .done(done), .rom_addr(rom_addr),
      .sample_valid(sample_valid), .sample_last(sample_last)
   );

   carrier_sequencer #(.ACC_W(16), .ADDR_W(8), .LEN_W(16), .ROM_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
      .cfg_fcw(cfg_fcw3), .cfg_phase(cfg_phase3), .cfg_len(cfg_len3),
      .start(start3), .abort(abort3), .busy(busy3), .done(done3), .rom_addr(rom_addr3),
      .sample_valid(sample_valid3), .sample_last(sample_last3)
   );

   // Cycle k after the start cycle is observed at its negedge; inputs set there apply to cycle k.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [3:0] f;
      f = {busy, done, sample_valid, sample_last};
      checks++;
      if (f !== 4'b0000) begin
         $display("FAIL reset_flags got=%b exp=0000", f); failures++;
      end
      checks++;
      if (rom_addr !== 8'h00) begin
         $display("FAIL reset_addr got=%h exp=00", rom_addr); failures++;
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
         $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); failures++;
      end
   endtask

   task automatic test_basic_burst;
      logic [3:0] f, ef;
      cfg_valid = 1'b1; cfg_fcw = 16'h0100; cfg_phase = 8'h00; cfg_len = 16'd4;
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         start = 1'b0;
         f  = {busy, done, sample_valid, sample_last};
         ef = {k <= 5, k == 6, (k >= 2 && k <= 5), k == 5};
         checks++;
         if (f !== ef) begin
            $display("FAIL basic_flags k=%0d got=%b exp=%b", k, f, ef); failures++;
         end
         checks++;
         if (rom_addr !== ((k <= 4) ? 8'(k - 1) : 8'h03)) begin
            $display("FAIL basic_addr k=%0d got=%h exp=%h", k, rom_addr,
                     (k <= 4) ? 8'(k - 1) : 8'h03);
            failures++;
         end
      end
   endtask

   task automatic test_wrap_bypass;
      logic [7:0] exp_addr [5] = '{8'hF0, 8'h30, 8'h70, 8'hB0, 8'hF0};
      logic [3:0] f, ef;
      cfg_valid = 1'b1; cfg_fcw = 16'h4000; cfg_phase = 8'hF0; cfg_len = 16'd5; start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         cfg_valid = 1'b0; start = 1'b0;
         f  = {busy, done, sample_valid, sample_last};
         ef = {k <= 6, k == 7, (k >= 2 && k <= 6), k == 6};
         checks++;
         if (f !== ef) begin
            $display("FAIL wrap_flags k=%0d got=%b exp=%b", k, f, ef); failures++;
         end
         if (k <= 5) begin
            checks++;
            if (rom_addr !== exp_addr[k-1]) begin
               $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, rom_addr, exp_addr[k-1]);
               failures++;
            end
         end
      end
   endtask

   task automatic test_zero_len;
      logic [3:0] f;
      cfg_valid = 1'b1; cfg_fcw = 16'h0100; cfg_phase = 8'h11; cfg_len = 16'd0; start = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b0;
      f = {busy, done, sample_valid, sample_last};
      checks++;
      if (f !== 4'b0100) begin
         $display("FAIL zlen_done got=%b exp=0100", f); failures++;
      end
      checks++;
      if (rom_addr !== 8'hF0 || cfg_ready !== 1'b1) begin
         $display("FAIL zlen_hold addr=%h ready=%b exp addr=f0 ready=1", rom_addr, cfg_ready);
         failures++;
      end
      @(negedge clk);
      f = {busy, done, sample_valid, sample_last};
      checks++;
      if (f !== 4'b0000) begin
         $display("FAIL zlen_after got=%b exp=0000", f); failures++;
      end
   endtask

   task automatic test_abort;
      logic [3:0] f, ef;
      cfg_valid = 1'b1; cfg_fcw = 16'h0100; cfg_phase = 8'h00; cfg_len = 16'd10; start = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
         if (k >= 2 && k <= 4) begin
            checks++;
            if (sample_valid !== 1'b1) begin
               $display("FAIL abort_pre_valid k=%0d got=%b exp=1", k, sample_valid); failures++;
            end
         end
         if (k == 4) abort = 1'b1;
         if (k >= 5) begin
            f = {busy, done, sample_valid, sample_last};
            checks++;
            if (f !== 4'b0000 || cfg_ready !== 1'b1) begin
               $display("FAIL abort_after k=%0d flags=%b ready=%b exp flags=0000 ready=1",
                        k, f, cfg_ready);
               failures++;
            end
         end
         if (k == 5) begin
            checks++;
            if (rom_addr !== 8'h03) begin
               $display("FAIL abort_addr_hold got=%h exp=03", rom_addr); failures++;
            end
         end
      end
      cfg_valid = 1'b1; cfg_fcw = 16'h0100; cfg_phase = 8'h10; cfg_len = 16'd2; start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         cfg_valid = 1'b0; start = 1'b0;
         f  = {busy, done, sample_valid, sample_last};
         ef = {k <= 3, k == 4, (k == 2 || k == 3), k == 3};
         checks++;
         if (f !== ef) begin
            $display("FAIL abort_rerun_flags k=%0d got=%b exp=%b", k, f, ef); failures++;
         end
         if (k <= 2) begin
            checks++;
            if (rom_addr !== 8'(8'h0F + k)) begin
               $display("FAIL abort_rerun_addr k=%0d got=%h exp=%h", k, rom_addr, 8'(8'h0F + k));
               failures++;
            end
         end
      end
   endtask

   task automatic test_busy_ignore;
      logic [3:0] f, ef;
      cfg_valid = 1'b1; cfg_fcw = 16'h0200; cfg_phase = 8'h00; cfg_len = 16'd3; start = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0; start = 1'b0;
            if (k == 1 && pass == 0) begin
               checks++;
               if (cfg_ready !== 1'b0) begin
                  $display("FAIL busy_cfg_ready got=%b exp=0", cfg_ready); failures++;
               end
               cfg_valid = 1'b1; cfg_fcw = 16'h1000; cfg_len = 16'd8; start = 1'b1;
            end
            f  = {busy, done, sample_valid, sample_last};
            ef = {k <= 4, k == 5, (k >= 2 && k <= 4), k == 4};
            checks++;
            if (f !== ef) begin
               $display("FAIL busy_flags pass=%0d k=%0d got=%b exp=%b", pass, k, f, ef);
               failures++;
            end
            if (k <= 3) begin
               checks++;
               if (rom_addr !== 8'(2 * (k - 1))) begin
                  $display("FAIL busy_addr pass=%0d k=%0d got=%h exp=%h", pass, k, rom_addr,
                           8'(2 * (k - 1)));
                  failures++;
               end
            end
         end
         start = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_burst;
      logic [3:0] f;
      cfg_valid = 1'b1; cfg_fcw = 16'h0100; cfg_phase = 8'h20; cfg_len = 16'd10; start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         cfg_valid = 1'b0; start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      f = {busy, done, sample_valid, sample_last};
      checks++;
      if (f !== 4'b0000 || rom_addr !== 8'h00 || cfg_ready !== 1'b1) begin
         $display("FAIL rst_mid flags=%b addr=%h ready=%b exp flags=0000 addr=00 ready=1",
                  f, rom_addr, cfg_ready);
         failures++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      f = {busy, done, sample_valid, sample_last};
      checks++;
      if (f !== 4'b0100 || rom_addr !== 8'h00) begin
         $display("FAIL rst_shadow_len flags=%b addr=%h exp flags=0100 addr=00", f, rom_addr);
         failures++;
      end
   endtask

   task automatic test_rom_lat3;
      logic [3:0] f, ef;
      cfg_valid3 = 1'b1; cfg_fcw3 = 16'h0100; cfg_phase3 = 8'h00; cfg_len3 = 16'd4; start3 = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         cfg_valid3 = 1'b0; start3 = 1'b0;
         f  = {busy3, done3, sample_valid3, sample_last3};
         ef = {k <= 7, k == 8, (k >= 4 && k <= 7), k == 7};
         checks++;
         if (f !== ef) begin
            $display("FAIL lat3_flags k=%0d got=%b exp=%b", k, f, ef); failures++;
         end
         if (k <= 4) begin
            checks++;
            if (rom_addr3 !== 8'(k - 1)) begin
               $display("FAIL lat3_addr k=%0d got=%h exp=%h", k, rom_addr3, 8'(k - 1));
               failures++;
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_cycles(2);
      test_reset;
      reset = 1'b0;
      idle_cycles(2);
      test_basic_burst;
      idle_cycles(2);
      test_wrap_bypass;
      idle_cycles(2);
      test_zero_len;
      idle_cycles(2);
      test_abort;
      idle_cycles(2);
      test_busy_ignore;
      idle_cycles(2);
      test_reset_mid_burst;
      idle_cycles(2);
      test_rom_lat3;
      idle_cycles(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
